// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the microcoded control sequencer: T-state encoding,
// opcodes, control-word bit positions, and step helpers.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CB_PC_INC     = 0;
  localparam int CB_PC_OUT     = 1;
  localparam int CB_PC_LOAD    = 2;
  localparam int CB_MAR_LOAD   = 3;
  localparam int CB_RAM_OUT    = 4;
  localparam int CB_RAM_LOAD   = 5;
  localparam int CB_IR_LOAD    = 6;
  localparam int CB_IR_OUT     = 7;
  localparam int CB_A_LOAD     = 8;
  localparam int CB_A_OUT      = 9;
  localparam int CB_B_LOAD     = 10;
  localparam int CB_ALU_OUT    = 11;
  localparam int CB_ALU_SUB    = 12;
  localparam int CB_OUT_LOAD   = 13;
  localparam int CB_FLAGS_LOAD = 14;

  localparam int CTRL_W = 16;
  typedef logic [CTRL_W-1:0] ctrl_word_t;

  function automatic t_state_e step_after(input t_state_e t);
    case (t)
      T0:      return T1;
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      default: return T0;
    endcase
  endfunction

  // Last T-state that carries an active step for the opcode.
  function automatic t_state_e last_step(input logic [3:0] op);
    case (op)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: return T2;
      OP_LDA, OP_STA:                               return T3;
      OP_ADD, OP_SUB:                               return T4;
      default:                                      return T1;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction/flag inputs and control/status outputs of the sequencer.
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic       input_run;
  logic [3:0] input_instruction;
  logic       input_carry_flag;
  logic       input_zero_flag;
  ctrl_word_t output_control;
  logic [2:0] output_t_state;
  logic       output_halted;

  modport master (
    output input_run, input_instruction, input_carry_flag, input_zero_flag,
    input  output_control, output_t_state, output_halted
  );

  modport slave (
    input  input_run, input_instruction, input_carry_flag, input_zero_flag,
    output output_control, output_t_state, output_halted
  );
endinterface

// File: rtl/control_sequencer_decoder.sv
// control_decoder: pure combinational map of (T-state, opcode, flags) to the
// 16-bit control word; run/halt gating lives in the sequencer.
module control_decoder
  import cpu_ctrl_pkg::*;
(
  input  t_state_e   t_state,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output ctrl_word_t control
);

  always_comb begin
    control = '0;
    case (t_state)
      T0: begin
        control[CB_PC_OUT]   = 1'b1;
        control[CB_MAR_LOAD] = 1'b1;
      end
      T1: begin
        control[CB_RAM_OUT] = 1'b1;
        control[CB_IR_LOAD] = 1'b1;
        control[CB_PC_INC]  = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            control[CB_IR_OUT]   = 1'b1;
            control[CB_MAR_LOAD] = 1'b1;
          end
          OP_LDI: begin
            control[CB_IR_OUT] = 1'b1;
            control[CB_A_LOAD] = 1'b1;
          end
          OP_JMP: begin
            control[CB_IR_OUT]  = 1'b1;
            control[CB_PC_LOAD] = 1'b1;
          end
          OP_JC: begin
            control[CB_IR_OUT]  = carry_flag;
            control[CB_PC_LOAD] = carry_flag;
          end
          OP_JZ: begin
            control[CB_IR_OUT]  = zero_flag;
            control[CB_PC_LOAD] = zero_flag;
          end
          OP_OUT: begin
            control[CB_A_OUT]    = 1'b1;
            control[CB_OUT_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            control[CB_RAM_OUT] = 1'b1;
            control[CB_A_LOAD]  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            control[CB_RAM_OUT] = 1'b1;
            control[CB_B_LOAD]  = 1'b1;
          end
          OP_STA: begin
            control[CB_A_OUT]    = 1'b1;
            control[CB_RAM_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          control[CB_ALU_OUT]    = 1'b1;
          control[CB_A_LOAD]     = 1'b1;
          control[CB_FLAGS_LOAD] = 1'b1;
          control[CB_ALU_SUB]    = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer with sticky halt and run gating; words come from control_decoder.
// Build option: define SEQ_EARLY_END_EN to return to T0 after an opcode's last active step.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                input_clear,
  control_sequencer_if.slave  bus
);
  // state | meaning
  // T0    | fetch: PC onto bus, load MAR
  // T1    | fetch: RAM into IR, increment PC
  // T2-T4 | execute steps, opcode dependent
  // halted flag overrides: T-state parks at T0, control word forced to 0

  t_state_e   t_state, t_next;
  logic       halted, halt_next;
  ctrl_word_t dec_word;

  control_decoder u_decoder (
    .t_state    (t_state),
    .opcode     (bus.input_instruction),
    .carry_flag (bus.input_carry_flag),
    .zero_flag  (bus.input_zero_flag),
    .control    (dec_word)
  );

  always_ff @(posedge clock or posedge input_clear) begin
    if (input_clear) begin
      t_state <= T0;
      halted  <= 1'b0;
    end else begin
      t_state <= t_next;
      halted  <= halt_next;
    end
  end

  always_comb begin
    t_next    = t_state;
    halt_next = halted;
    if (halted) begin
      t_next = T0;
    end else if (bus.input_run) begin
      if (t_state == T2 && bus.input_instruction == OP_HLT)
        halt_next = 1'b1;
`ifdef SEQ_EARLY_END_EN
      if (t_state >= last_step(bus.input_instruction))
        t_next = T0;
      else
        t_next = step_after(t_state);
`else
      t_next = step_after(t_state);
`endif
    end
  end

  always_comb begin
    bus.output_control = '0;
    if (bus.input_run && !halted)
      bus.output_control = dec_word;
    bus.output_t_state = t_state;
    bus.output_halted  = halted;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none; all widths and encodings are fixed by the shared package.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 input_clear  in  1  reset, asynchronous, active-high.
REQ-004 input_run  in  1  1 = advance T-state each edge; 0 = freeze T-state, force control word to 0.
REQ-005 input_instruction  in  4  opcode, instruction register upper nibble; sampled combinationally in T2..T4.
REQ-006 input_carry_flag  in  1  carry flag from the flags register.
REQ-007 input_zero_flag  in  1  zero flag from the flags register.
REQ-008 output_control  out  16  control word driving register CE/OE lines; bit map given in REQ-012.
REQ-009 output_t_state  out  3  current T-state, 0..4.
REQ-010 output_halted  out  1  1 after an HLT executes; sticky until reset.

Function
REQ-011 output_control SHALL be combinational from (T-state, opcode, flags, run, halted); downstream registers act on it at the edge ending the T-state.
REQ-012 Bit map: 0 PC_INC, 1 PC_OUT, 2 PC_LOAD, 3 MAR_LOAD, 4 RAM_OUT, 5 RAM_LOAD, 6 IR_LOAD, 7 IR_OUT, 8 A_LOAD, 9 A_OUT, 10 B_LOAD, 11 ALU_OUT, 12 ALU_SUB, 13 OUT_LOAD, 14 FLAGS_LOAD, 15 reserved, always 0.
REQ-013 Fetch steps for every opcode: T0 = PC_OUT|MAR_LOAD (0x000A); T1 = RAM_OUT|IR_LOAD|PC_INC (0x0051).
REQ-014 Opcode map: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; 9..D SHALL decode as NOP.
REQ-015 LDA: T2 IR_OUT|MAR_LOAD (0x0088); T3 RAM_OUT|A_LOAD (0x0110).
REQ-016 ADD: T2 0x0088; T3 RAM_OUT|B_LOAD (0x0410); T4 ALU_OUT|A_LOAD|FLAGS_LOAD (0x4900). SUB: as ADD, with T4 = 0x5900 (adds ALU_SUB).
REQ-017 STA: T2 0x0088; T3 A_OUT|RAM_LOAD (0x0220). LDI: T2 IR_OUT|A_LOAD (0x0180). JMP: T2 IR_OUT|PC_LOAD (0x0084).
REQ-018 JC/JZ: T2 0x0084 if the respective flag = 1, else 0x0000.
REQ-019 OUT: T2 A_OUT|OUT_LOAD (0x2200).
REQ-020 HLT: T2 word = 0x0000; output_halted SHALL set at the edge ending T2.
REQ-021 All execute steps not listed above SHALL drive 0x0000.
REQ-022 T-state sequence: T0->T1->T2->T3->T4->T0 while input_run = 1 and not halted. Early termination applies only per REQ-028.
REQ-023 input_run = 0: T-state holds and output_control = 0; stepping resumes from the same T-state when input_run returns to 1.
REQ-024 Halted: T-state SHALL be forced to 0 at the next edge and then hold; output_control = 0; only input_clear exits.

Reset
REQ-025 input_clear = 1 SHALL asynchronously force T-state = 0 and output_halted = 0, overriding run and halt, including mid-instruction.
REQ-026 During and after reset, output_control SHALL equal the T0 word 0x000A if input_run = 1, else 0x0000.
REQ-027 The first edge after reset deassertion SHALL advance T0->T1 when input_run = 1.

Configuration
REQ-028 Macro SEQ_EARLY_END_EN:
- Defined: after an opcode's last active step the next state is T0.
- Last steps: NOP and undefined opcodes end at T1; LDI, JMP, JC, JZ, OUT, HLT end at T2; LDA, STA end at T3; ADD, SUB end at T4.
- JC/JZ not taken still end at T2.
- Undefined: every instruction takes the full 5 T-states.

Structure
REQ-029 Package cpu_ctrl_pkg SHALL hold the opcode constants, control-bit indices and T-state encodings; it is shared with the datapath and the bench.
REQ-030 Sub-module control_decoder: combinational map of (T-state, opcode, flags) to the 16-bit word. control_sequencer owns the T-state counter, halt flop and run/halt gating.

Verification
REQ-031 Reset asserted in T3 of LDA -> T-state 0 immediately, without a clock edge; control 0x000A; halted 0.
REQ-032 Opcode 2 (ADD), run = 1 -> control per T-state: 0x000A, 0x0051, 0x0088, 0x0410, 0x4900, then T0 again.
REQ-033 Opcode 8 (JZ), zero = 1 -> T2 word 0x0084. Zero = 0 -> T2 word 0x0000. Each case checked with the macro defined (T2->T0) and undefined (T2->T3).
REQ-034 Opcode F (HLT) -> halted = 1 after T2; T-state 0; control 0x0000 for 10 further cycles; reset clears it.
REQ-035 input_run dropped in T2 of OUT for 3 cycles -> T-state stays 2, control 0x0000; on resume, 0x2200 is output.
REQ-036 Opcode B (undefined) -> T2..T4 all 0x0000. With the macro defined, T1 is followed by T0.
